eth_arp_recv: RTL

//  GMII receive-side ARP frame parser; the counterpart of the GMII ARP transmitter. Strips

---
 rtl/eth_pkg.sv | 24 ++
 rtl/crc32_d8.sv | 31 +++
 rtl/eth_arp_recv.sv | 132 +++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet/ARP constants and ARP receive FSM states
package eth_pkg;
   localparam logic [15:0] ETH_TYPE_ARP    = 16'h0806;
   localparam logic [15:0] ARP_HTYPE_ETH   = 16'h0001;
   localparam logic [15:0] ARP_PTYPE_IPV4  = 16'h0800;
   localparam logic [7:0]  ARP_HLEN_ETH    = 8'd6;
   localparam logic [7:0]  ARP_PLEN_IPV4   = 8'd4;
   localparam logic [15:0] ARP_OPER_REQ    = 16'd1;
   localparam logic [15:0] ARP_OPER_REP    = 16'd2;
   localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
   localparam logic [7:0]  SFD_BYTE        = 8'hD5;
   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
   localparam logic [10:0] ETH_MIN_FRAME   = 11'd64;

   typedef enum logic [2:0] {
      ST_WAIT_IDLE,
      ST_IDLE,
      ST_PREAMBLE,
      ST_BODY,
      ST_DROP,
      ST_END
   } arp_rx_state_e;
endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - byte-parallel reflected CRC-32 register (init all ones, no final inversion)
module crc32_d8 (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);
   import eth_pkg::*;

   logic [31:0] crc_next;

   // Eight LSB-first serial steps unrolled into one cycle
   always_comb begin
      crc_next = crc;
      for (int i = 0; i < 8; i++) begin
         if (crc_next[0] ^ data[i])
            crc_next = (crc_next >> 1) ^ CRC32_POLY_REFL;
         else
            crc_next = crc_next >> 1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr)
         crc <= '1;
      else if (en)
         crc <= crc_next;
   end
endmodule

// File: rtl/eth_arp_recv.sv
// rtl/eth_arp_recv.sv - GMII RX ARP parser: preamble strip, MAC/ethertype filter, FCS/length check
module eth_arp_recv #(
   parameter logic [47:0] LOCAL_MAC = 48'h0007EDAC6200,
   parameter logic [31:0] LOCAL_IP  = 32'hC0A80002,
   parameter int          MAX_FRAME = 1518
) (
   input  logic        gmii_rx_clk,
   input  logic        rst,
   input  logic [7:0]  gmii_rx_data,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   output logic        arp_valid,
   output logic [15:0] arp_opcode,
   output logic [47:0] arp_sender_mac,
   output logic [31:0] arp_sender_ip,
   output logic        frame_err
);
   import eth_pkg::*;

   localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME);
   localparam logic [10:0] SAT_CNT = 11'(MAX_FRAME + 1);

   arp_rx_state_e state, state_d;
   logic [10:0] byte_cnt, cnt_inc;
   logic [47:0] dst_mac, sha;
   logic [31:0] spa, tpa, crc;
   logic [15:0] eth_type, htype, ptype, oper;
   logic [7:0]  hlen, plen;
   logic        sfd_seen, body_byte, match, good;
   logic        arp_valid_d, frame_err_d;

   assign cnt_inc   = (byte_cnt == SAT_CNT) ? byte_cnt : byte_cnt + 11'd1;
   assign sfd_seen  = (state == ST_PREAMBLE) && gmii_rx_dv && !gmii_rx_er && (gmii_rx_data == SFD_BYTE);
   assign body_byte = (state == ST_BODY) && gmii_rx_dv;

   crc32_d8 u_crc (
      .clk  (gmii_rx_clk),
      .rst  (rst),
      .clr  (sfd_seen),
      .en   (body_byte),
      .data (gmii_rx_data),
      .crc  (crc)
   );

   assign match = ((dst_mac == '1) || (dst_mac == LOCAL_MAC)) &&
                  (eth_type == ETH_TYPE_ARP) && (htype == ARP_HTYPE_ETH) &&
                  (ptype == ARP_PTYPE_IPV4) && (hlen == ARP_HLEN_ETH) && (plen == ARP_PLEN_IPV4) &&
                  ((oper == ARP_OPER_REQ) || (oper == ARP_OPER_REP)) && (tpa == LOCAL_IP);
   assign good  = (crc == CRC32_RESIDUE) && (byte_cnt >= ETH_MIN_FRAME);

   always_comb begin
      state_d     = state;
      arp_valid_d = 1'b0;
      frame_err_d = 1'b0;
      case (state)
         ST_WAIT_IDLE: if (!gmii_rx_dv) state_d = ST_IDLE;
         ST_IDLE: begin
            if (gmii_rx_dv)
               state_d = (gmii_rx_data == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
         end
         ST_PREAMBLE: begin
            if (!gmii_rx_dv)
               state_d = ST_IDLE;
            else if (gmii_rx_er) begin
               state_d     = ST_DROP;
               frame_err_d = 1'b1;
            end else if (gmii_rx_data == SFD_BYTE)
               state_d = ST_BODY;
            else if (gmii_rx_data != PREAMBLE_BYTE)
               state_d = ST_DROP;
         end
         ST_BODY: begin
            // Decision is registered so the pulse lands one cycle after dv is seen low
            if (!gmii_rx_dv) begin
               state_d     = ST_END;
               frame_err_d = !good;
               arp_valid_d = good && match;
            end else if (gmii_rx_er || (cnt_inc > MAX_CNT)) begin
               state_d     = ST_DROP;
               frame_err_d = 1'b1;
            end
         end
         ST_DROP: if (!gmii_rx_dv) state_d = ST_IDLE;
         ST_END:  state_d = ST_IDLE;
         default: state_d = ST_WAIT_IDLE;
      endcase
   end

   always_ff @(posedge gmii_rx_clk) begin
      if (rst) begin
         state          <= ST_WAIT_IDLE;
         byte_cnt       <= '0;
         arp_valid      <= 1'b0;
         frame_err      <= 1'b0;
         arp_opcode     <= '0;
         arp_sender_mac <= '0;
         arp_sender_ip  <= '0;
      end else begin
         state     <= state_d;
         arp_valid <= arp_valid_d;
         frame_err <= frame_err_d;
         if (arp_valid_d) begin
            arp_opcode     <= oper;
            arp_sender_mac <= sha;
            arp_sender_ip  <= spa;
         end
         if (sfd_seen)
            byte_cnt <= '0;
         else if (body_byte)
            byte_cnt <= cnt_inc;
      end
   end

   // Header shadow registers, filled MSB first by byte offset
   always_ff @(posedge gmii_rx_clk) begin
      if (body_byte) begin
         case (byte_cnt) inside
            [11'd0:11'd5]:   dst_mac  <= {dst_mac[39:0], gmii_rx_data};
            [11'd12:11'd13]: eth_type <= {eth_type[7:0], gmii_rx_data};
            [11'd14:11'd15]: htype    <= {htype[7:0], gmii_rx_data};
            [11'd16:11'd17]: ptype    <= {ptype[7:0], gmii_rx_data};
            11'd18:          hlen     <= gmii_rx_data;
            11'd19:          plen     <= gmii_rx_data;
            [11'd20:11'd21]: oper     <= {oper[7:0], gmii_rx_data};
            [11'd22:11'd27]: sha      <= {sha[39:0], gmii_rx_data};
            [11'd28:11'd31]: spa      <= {spa[23:0], gmii_rx_data};
            [11'd38:11'd41]: tpa      <= {tpa[23:0], gmii_rx_data};
            default: ;
         endcase
      end
   end
endmodule
